matrix_scan_capture: RTL

Receive-side monitor for the 5x7 LED matrix scan interface. It watches the active-low column strobes and the five row lines that the matrix driver emits, and rebuilds each complete 35-pixel frame. It also checks that the scan sequence is legal and flags frames whose content changed, so a scroll step can be seen. It sits on the board-side pins, or in the bench next to the driver, as the consumer of the column/row interface.

---
 rtl/matrix_scan_pkg.sv | 35 +++
 rtl/matrix_scan_capture_sync.sv | 27 ++
 rtl/matrix_scan_capture.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_pkg.sv
// Shared types and constants for the 5x7 LED matrix scan monitor.
// Column-code decode helper returns the strobed column index plus a one-hot valid flag.
package matrix_scan_pkg;

  localparam int N_COLS  = 7;
  localparam int N_ROWS  = 5;
  localparam int FRAME_W = N_COLS * N_ROWS;

  typedef enum logic [1:0] {
    HUNT,
    CAPTURE,
    PUBLISH
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } col_dec_t;

  function automatic col_dec_t col_onehot_to_idx(input logic [N_COLS-1:0] col_n);
    col_dec_t d;
    int       n_low;
    d     = '0;
    n_low = 0;
    for (int i = 0; i < N_COLS; i++) begin
      if (!col_n[i]) begin
        n_low++;
        d.idx = 3'(i);
      end
    end
    d.vld = (n_low == 1);
    return d;
  endfunction

endpackage

// File: rtl/matrix_scan_capture_sync.sv
// Multi-stage input synchronizer with a configurable reset value; latency STAGES cycles.
// No backpressure: free-running shift chain.
module scan_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stg [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= RST_VAL;
    end else begin
      r_stg[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q = r_stg[STAGES-1];

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds 35-pixel frames from the active-low column strobes and row lines, checks scan order.
// Row sample SYNC_STAGES+SETTLE_CYCLES-1 edges after a column change; publish one cycle later; no backpressure.
module matrix_scan_capture
  import matrix_scan_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_COLS-1:0]    i_col_n,
  input  logic [N_ROWS-1:0]    i_row,
  output logic [FRAME_W-1:0]   o_frame_data,
  output logic                 o_frame_valid,
  output logic                 o_frame_changed,
  output logic                 o_scan_err,
  output logic [ERR_W-1:0]     o_err_cnt,
  output logic [2:0]           o_cur_col
);

  localparam int              CNT_W     = 4;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);
  localparam logic [2:0]      COL_FIRST = 3'(N_COLS - 1);

  logic [N_COLS-1:0]  w_col;
  logic [N_ROWS-1:0]  w_row;

  scan_sync #(.W(N_COLS), .STAGES(SYNC_STAGES), .RST_VAL({N_COLS{1'b1}})) u_sync_col (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_col_n),
    .o_q     (w_col)
  );

  scan_sync #(.W(N_ROWS), .STAGES(SYNC_STAGES), .RST_VAL({N_ROWS{1'b0}})) u_sync_row (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_row),
    .o_q     (w_row)
  );

  // w_cnt is the dwell age of the current code; it reads 0 on the cycle the code changes
  logic [N_COLS-1:0] r_col_prev;
  logic [CNT_W-1:0]  r_stab;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_settled;
  logic              w_idle;
  col_dec_t          w_dec;

  assign w_cnt     = (w_col != r_col_prev) ? '0 : r_stab;
  assign w_settled = (w_cnt == SETTLE_C - 1'b1);
  assign w_idle    = &w_col;
  assign w_dec     = col_onehot_to_idx(w_col);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col_prev <= '1;
      r_stab     <= '0;
    end else begin
      r_col_prev <= w_col;
      r_stab     <= (w_cnt == SETTLE_C) ? SETTLE_C : w_cnt + 1'b1;
    end
  end

  state_t     r_state, w_state_nxt;
  logic [2:0] r_exp, w_exp_nxt;
  logic       w_wr;
  logic       w_err;
  logic       w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HUNT;
      r_exp   <= COL_FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_wr        = 1'b0;
    w_err       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_settled && w_dec.vld && (w_dec.idx == COL_FIRST)) begin
          w_wr        = 1'b1;
          w_exp_nxt   = COL_FIRST - 3'd1;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_settled) begin
          if (w_dec.vld && (w_dec.idx == r_exp)) begin
            w_wr = 1'b1;
            if (r_exp == 3'd0) begin
              w_last      = 1'b1;
              w_state_nxt = PUBLISH;
            end else begin
              w_exp_nxt = r_exp - 3'd1;
            end
          end else if (!w_idle) begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
          end
        end
      end
      PUBLISH: begin
        w_exp_nxt   = COL_FIRST;
        w_state_nxt = CAPTURE;
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Frame is assembled on the column-0 write so it is already visible in the PUBLISH cycle
  logic [N_ROWS-1:0]  r_shadow [N_COLS];
  logic [FRAME_W-1:0] w_frame_nxt;

  always_comb begin
    w_frame_nxt = '0;
    for (int c = 0; c < N_COLS; c++) w_frame_nxt[c*N_ROWS +: N_ROWS] = r_shadow[c];
    w_frame_nxt[N_ROWS-1:0] = w_row;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_COLS; c++) r_shadow[c] <= '0;
    end else if (w_err) begin
      for (int c = 0; c < N_COLS; c++) r_shadow[c] <= '0;
    end else if (w_wr) begin
      r_shadow[w_dec.idx] <= w_row;
    end
  end

  logic [FRAME_W-1:0] r_frame;
  logic               r_fv;
  logic               r_fc;
  logic               r_err;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [2:0]         r_cur_col;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame   <= '0;
      r_fv      <= 1'b0;
      r_fc      <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_cur_col <= 3'd7;
    end else begin
      r_fv  <= w_last;
      r_fc  <= w_last && (w_frame_nxt != r_frame);
      r_err <= w_err;
      if (w_last) r_frame <= w_frame_nxt;
      if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_wr) r_cur_col <= w_dec.idx;
    end
  end

  assign o_frame_data    = r_frame;
  assign o_frame_valid   = r_fv;
  assign o_frame_changed = r_fc;
  assign o_scan_err      = r_err;
  assign o_err_cnt       = r_err_cnt;
  assign o_cur_col       = r_cur_col;

endmodule
